// File: rtl/uart_fifo_pkg.sv
// uart_fifo_port shared definitions:
// register map, STATUS/CTRL bit positions and FSM encodings.
package uart_fifo_pkg;

  localparam logic [4:0] OFF_TXDATA = 5'h00;
  localparam logic [4:0] OFF_RXDATA = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_CTRL   = 5'h0C;
  localparam logic [4:0] OFF_DIV    = 5'h10;

  localparam int STS_TX_IDLE   = 0;
  localparam int STS_TX_NFULL  = 1;
  localparam int STS_RX_NEMPTY = 2;
  localparam int STS_RX_OVR    = 3;
  localparam int STS_FRM_ERR   = 4;
  localparam int STS_TXCNT     = 8;
  localparam int STS_RXCNT     = 16;

  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_st_e;

  function automatic logic [7:0] cnt8(input logic [31:0] c);
    return c[7:0];
  endfunction

endpackage

// File: rtl/uart_fifo_port_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// A push into a full FIFO is taken only when a pop frees a slot.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      sysclk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [DATA_W-1:0]         din,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic do_push, do_pop;

  assign count   = wptr_q - rptr_q;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + ONE;
      if (do_pop)  rptr_q <= rptr_q + ONE;
    end
  end

  always_ff @(posedge sysclk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_fifo_port.sv
// Memory-mapped UART: TX/RX FIFOs, baud divisor,
// sticky error flags and a level interrupt.
module uart_fifo_port #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 325
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);
  import uart_fifo_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  logic [4:0] a;
  logic sel_tx, sel_rx, sel_st, sel_ct, sel_dv;
  logic unused_ok;

  assign a      = {addr[4:2], 2'b00};
  assign sel_tx = a == OFF_TXDATA;
  assign sel_rx = a == OFF_RXDATA;
  assign sel_st = a == OFF_STATUS;
  assign sel_ct = a == OFF_CTRL;
  assign sel_dv = a == OFF_DIV;
  assign unused_ok = ^{addr[1:0], wdata};

  logic [DIV_W-1:0] div_q, bcnt_q;
  logic tick;
  logic rx_ie_q, tx_ie_q, ovr_q, ferr_q;
  logic ovr_set, ferr_set;

  logic tx_push, tx_pop, tx_full, tx_empty;
  logic [DATA_W-1:0] tx_dout;
  logic [CW-1:0] tx_cnt;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [DATA_W-1:0] rx_dout;
  logic [CW-1:0] rx_cnt;

  assign tx_push = wr & sel_tx;
  assign rx_pop  = rd & sel_rx;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .sysclk(sysclk), .reset(reset),
    .push(tx_push), .pop(tx_pop),
    .din(wdata[DATA_W-1:0]), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .count(tx_cnt)
  );

  uart_st_e rx_st_q, rx_st_d;
  logic [3:0] rx_tc_q, rx_tc_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .sysclk(sysclk), .reset(reset),
    .push(rx_push), .pop(rx_pop),
    .din(rx_sh_q), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .count(rx_cnt)
  );

  assign tick = bcnt_q == '0;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) bcnt_q <= DIV_W'(DEFAULT_DIV);
    else bcnt_q <= tick ? div_q : bcnt_q - DIV_W'(1);
  end

  // a set event in the same cycle beats the W1C
  assign ovr_set = rx_push & rx_full & ~rx_pop;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      div_q   <= DIV_W'(DEFAULT_DIV);
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      if (wr & sel_dv) div_q <= wdata[DIV_W-1:0];
      if (wr & sel_ct) begin
        rx_ie_q <= wdata[CTRL_RX_IE];
        tx_ie_q <= wdata[CTRL_TX_IE];
      end
      ovr_q  <= ovr_set |
                (ovr_q & ~(wr & sel_st & wdata[STS_RX_OVR]));
      ferr_q <= ferr_set |
                (ferr_q & ~(wr & sel_st & wdata[STS_FRM_ERR]));
    end
  end

  uart_st_e tx_st_q, tx_st_d;
  logic [3:0] tx_tc_q, tx_tc_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic tx_end, tx_idle;

  assign tx_end  = tick & (tx_tc_q == 4'd15);
  assign tx_idle = (tx_st_q == S_IDLE) & tx_empty;

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_tc_d  = tx_tc_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    tx_pop   = 1'b0;
    tx       = 1'b1;
    if (tick && tx_st_q != S_IDLE) tx_tc_d = tx_tc_q + 4'd1;
    unique case (tx_st_q)
      S_IDLE: if (tick && !tx_empty) begin
        tx_pop  = 1'b1;
        tx_sh_d = tx_dout;
        tx_tc_d = '0;
        tx_st_d = S_START;
      end
      S_START: begin
        tx = 1'b0;
        if (tx_end) begin
          tx_st_d  = S_DATA;
          tx_bit_d = '0;
        end
      end
      S_DATA: begin
        tx = tx_sh_q[0];
        if (tx_end) begin
          tx_sh_d  = tx_sh_q >> 1;
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == LAST_BIT) tx_st_d = S_STOP;
        end
      end
      S_STOP: if (tx_end) begin
        if (!tx_empty) begin
          tx_pop  = 1'b1;
          tx_sh_d = tx_dout;
          tx_st_d = S_START;
        end else begin
          tx_st_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  logic [2:0] rxs_q;
  logic rx_s, rx_fall, rx_mid, rx_end;

  assign rx_s    = rxs_q[1];
  assign rx_fall = rxs_q[2] & ~rx_s;
  assign rx_mid  = tick & (rx_tc_q == 4'd7);
  assign rx_end  = tick & (rx_tc_q == 4'd15);

  always_comb begin
    rx_st_d  = rx_st_q;
    rx_tc_d  = rx_tc_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d  = rx_sh_q;
    rx_push  = 1'b0;
    ferr_set = 1'b0;
    if (tick && rx_st_q != S_IDLE) rx_tc_d = rx_tc_q + 4'd1;
    unique case (rx_st_q)
      S_IDLE: if (rx_fall) begin
        rx_tc_d = '0;
        rx_st_d = S_START;
      end
      S_START: begin
        if (rx_mid && rx_s) rx_st_d = S_IDLE;
        else if (rx_end) begin
          rx_st_d  = S_DATA;
          rx_bit_d = '0;
        end
      end
      S_DATA: begin
        if (rx_mid) rx_sh_d = {rx_s, rx_sh_q[DATA_W-1:1]};
        if (rx_end) begin
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == LAST_BIT) rx_st_d = S_STOP;
        end
      end
      S_STOP: if (rx_mid) begin
        rx_push  = rx_s;
        ferr_set = ~rx_s;
        rx_st_d  = S_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      tx_st_q  <= S_IDLE;
      tx_tc_q  <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
      rx_st_q  <= S_IDLE;
      rx_tc_q  <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      rxs_q    <= 3'b111;
    end else begin
      tx_st_q  <= tx_st_d;
      tx_tc_q  <= tx_tc_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q  <= tx_sh_d;
      rx_st_q  <= rx_st_d;
      rx_tc_q  <= rx_tc_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q  <= rx_sh_d;
      rxs_q    <= {rxs_q[1:0], rx};
    end
  end

  logic [31:0] status;

  always_comb begin
    status = '0;
    status[STS_TX_IDLE]   = tx_idle;
    status[STS_TX_NFULL]  = ~tx_full;
    status[STS_RX_NEMPTY] = ~rx_empty;
    status[STS_RX_OVR]    = ovr_q;
    status[STS_FRM_ERR]   = ferr_q;
    status[STS_TXCNT +: 8] = cnt8(32'(tx_cnt));
    status[STS_RXCNT +: 8] = cnt8(32'(rx_cnt));
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        sel_rx: if (!rx_empty) rdata = 32'(rx_dout);
        sel_st: rdata = status;
        sel_ct: rdata[1:0] = {tx_ie_q, rx_ie_q};
        sel_dv: rdata = 32'(div_q);
        default: ;
      endcase
    end
  end

  assign irq = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_idle) |
               ovr_q | ferr_q;

endmodule

// File: tb/tb_uart_fifo_port.sv
// Scoreboard bench for uart_fifo_port: serial TX monitor
// against expected queue, RX FIFO reference model, register checks.
module tb_uart_fifo_port;
  import uart_fifo_pkg::*;

  logic sysclk = 1'b0;
  logic reset = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic rx, tx, irq;
  logic rx_drv = 1'b1, loop = 1'b0;

  assign rx = loop ? tx : rx_drv;

  uart_fifo_port dut (
    .sysclk(sysclk), .reset(reset), .rd(rd), .wr(wr),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .rx(rx), .tx(tx), .irq(irq)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0, errors = 0, cyc = 0;
  int bitc = 16 * 326;
  logic mon_en = 1'b0;
  logic [7:0] exp_tx[$];
  logic [7:0] rx_model[$];
  logic model_ovr = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // serial TX monitor: decodes each frame at bit midpoints
  initial begin : tx_mon
    logic [9:0] f;
    forever begin
      @(negedge tx);
      if (mon_en) begin
        repeat (bitc / 2) @(posedge sysclk);
        #1 f[0] = tx;
        for (int i = 1; i < 10; i++) begin
          repeat (bitc) @(posedge sysclk);
          #1 f[i] = tx;
        end
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_frame got %0h want none", f);
        end else begin
          check("tx_frame", 32'(f), {22'b0, 1'b1, exp_tx.pop_front(), 1'b0});
        end
      end
    end
  end

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge sysclk);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge sysclk);
    #1 wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge sysclk);
    addr = a; rd = 1'b1;
    #1 d = rdata;
    @(posedge sysclk);
    #1 rd = 1'b0;
  endtask

  task automatic tx_write(input logic [7:0] b);
    bus_write(OFF_TXDATA, {24'b0, b});
    exp_tx.push_back(b);
  endtask

  task automatic wait_status(input int bitn, input int maxp);
    logic [31:0] s;
    int n;
    n = 0;
    s = '0;
    while (!s[bitn] && n < maxp) begin
      bus_read(OFF_STATUS, s);
      n++;
    end
    check($sformatf("status_wait_bit%0d", bitn), 32'(s[bitn]), 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    logic [9:0] f;
    f = {stopb, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge sysclk);
      rx_drv = f[i];
      repeat (bitc - 1) @(negedge sysclk);
    end
    @(negedge sysclk);
    rx_drv = 1'b1;
  endtask

  initial begin : watchdog
    #(10 * 200000);
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] r, exp_st;
    logic [7:0] b;
    int n, t0;

    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    #1;
    check("reset_tx", 32'(tx), 1);
    check("reset_irq", 32'(irq), 0);
    bus_read(OFF_STATUS, r); check("reset_status", r, 32'h3);
    bus_read(OFF_CTRL, r);   check("reset_ctrl", r, 0);
    bus_read(OFF_DIV, r);    check("reset_div", r, 325);
    bus_read(OFF_RXDATA, r); check("empty_rxdata", r, 0);
    bus_read(OFF_TXDATA, r); check("txdata_read", r, 0);
    bus_read(5'h14, r);      check("unmapped_read", r, 0);

    bus_write(OFF_DIV, 32'd3);
    bitc = 64;
    bus_read(OFF_DIV, r); check("div_rw", r, 3);
    repeat (400) @(posedge sysclk);
    mon_en = 1'b1;

    tx_write(8'h55);
    n = 0;
    while (tx && n < 50) begin
      @(posedge sysclk);
      #1 n++;
    end
    t0 = cyc;
    check("tx_start_latency", 32'(n >= 1 && n <= 5), 1);
    tx_write(8'hA3);
    while (cyc < t0 + 1240) @(posedge sysclk);
    bus_read(OFF_STATUS, r); check("tx_busy_2nd", 32'(r[0]), 0);
    while (cyc < t0 + 1320) @(posedge sysclk);
    bus_read(OFF_STATUS, r); check("tx_idle_after", 32'(r[0]), 1);

    for (int i = 0; i < 5; i++) tx_write(8'($urandom));
    wait_status(STS_TX_IDLE, 20000);

    loop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_status(STS_TX_NFULL, 20000);
      tx_write(8'(i));
      if (rx_model.size() < 16) rx_model.push_back(8'(i));
      else model_ovr = 1'b1;
    end
    wait_status(STS_TX_IDLE, 20000);
    repeat (200) @(posedge sysclk);
    loop = 1'b0;
    exp_st = 32'h3 | (32'(model_ovr) << 3) |
             (32'(rx_model.size()) << 16) |
             ((rx_model.size() != 0) ? 32'h4 : 32'h0);
    bus_read(OFF_STATUS, r); check("loop_status", r, exp_st);
    check("loop_irq", 32'(irq), 1);
    for (int i = 0; i < 17; i++) begin
      bus_read(OFF_RXDATA, r);
      check($sformatf("loop_rd%0d", i), r,
            rx_model.size() != 0 ? 32'(rx_model.pop_front()) : 0);
    end
    bus_write(OFF_STATUS, 32'h8);
    bus_read(OFF_STATUS, r); check("ovr_w1c", r, 32'h3);
    check("ovr_w1c_irq", 32'(irq), 0);

    send_rx(8'h41, 1'b0);
    repeat (100) @(posedge sysclk);
    bus_read(OFF_STATUS, r); check("ferr_status", r, 32'h13);
    check("ferr_irq", 32'(irq), 1);
    bus_write(OFF_STATUS, 32'h10);
    bus_read(OFF_STATUS, r); check("ferr_w1c", r, 32'h3);
    check("ferr_w1c_irq", 32'(irq), 0);

    @(negedge sysclk);
    rx_drv = 1'b0;
    repeat (16) @(negedge sysclk);
    rx_drv = 1'b1;
    repeat (200) @(posedge sysclk);
    bus_read(OFF_STATUS, r); check("glitch_status", r, 32'h3);

    bus_write(OFF_CTRL, 32'h1);
    b = 8'($urandom);
    send_rx(b, 1'b1);
    repeat (100) @(posedge sysclk);
    check("rxie_irq", 32'(irq), 1);
    bus_read(OFF_RXDATA, r); check("rxie_data", r, 32'(b));
    check("rxie_irq_clr", 32'(irq), 0);
    bus_write(OFF_CTRL, 32'h2);
    check("txie_irq", 32'(irq), 1);
    bus_write(OFF_CTRL, 32'h0);
    check("ie_off_irq", 32'(irq), 0);

    mon_en = 1'b0;
    b = 8'($urandom) & 8'hF7;
    bus_write(OFF_TXDATA, {24'b0, b});
    repeat (292) @(posedge sysclk);
    #2 check("pre_reset_tx", 32'(tx), 0);
    reset = 1'b1;
    #1;
    check("reset_mid_tx", 32'(tx), 1);
    check("reset_mid_irq", 32'(irq), 0);
    repeat (3) @(negedge sysclk);
    reset = 1'b0;
    bus_read(OFF_STATUS, r); check("reset_mid_status", r, 32'h3);
    bus_read(OFF_DIV, r);    check("reset_mid_div", r, 325);
    bus_write(OFF_DIV, 32'd3);
    repeat (400) @(posedge sysclk);
    mon_en = 1'b1;
    tx_write(8'($urandom));
    wait_status(STS_TX_IDLE, 20000);
    repeat (20) @(posedge sysclk);

    check("tx_queue_drained", 32'(exp_tx.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
